// File: rtl/neander_alu_pkg.sv
// neander_alu_pkg: shared types for the NEANDER sequential ALU.
//   alu_op_e    - 4-bit opcode map, same encoding as the NEANDER-X ALU
//   alu_state_e - control states of the sequential wrapper (IDLE/RUN/DONE)
//   OP_RESERVED - opcode F, produces a zero result with only `zero` set
//   add_ovf/sub_ovf - signed overflow from the operand and result sign bits
package neander_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_XOR = 4'h4, OP_NOT = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
    OP_NEG = 4'h8, OP_MUL = 4'h9, OP_DIV = 4'hA, OP_MOD = 4'hB,
    OP_ADC = 4'hC, OP_SBC = 4'hD, OP_ASR = 4'hE, OP_RSV = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam alu_op_e OP_RESERVED = OP_RSV;

  // Addition overflows when both operands share a sign the result lacks.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Subtraction overflows when operand signs differ and the result loses a's sign.
  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/neander_seq_muldiv.sv
// neander_seq_muldiv: iterative unsigned multiply / restoring divide engine.
//   load    - capture a, b and is_div, clear the partial remainder/high half
//   step    - perform one shift-add (MUL) or restoring-subtract (DIV) step
//   prod_hi/prod_lo, rem/quot - value AFTER the step in progress, so the
//   caller can register the final answer on the same edge as the last step.
// Only instantiated when NEANDER_SEQ_ALU_MULDIV_EN is defined.
module neander_seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);
  import neander_alu_pkg::*;

  // acc holds the product high half / partial remainder; lo holds the
  // multiplier bits / dividend bits being replaced by quotient bits.
  logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, b_q, b_d;
  logic             div_q, div_d;
  logic [WIDTH:0]   mul_sum_s, div_shift_s, div_diff_s;
  logic [WIDTH-1:0] acc_nx_s, lo_nx_s;

  // One iteration of either algorithm.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_q, lo_q[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, b_q};
    if (div_q) begin
      // Top bit of the difference is the borrow: set means restore.
      if (!div_diff_s[WIDTH]) begin
        acc_nx_s = div_diff_s[WIDTH-1:0];
        lo_nx_s  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx_s = div_shift_s[WIDTH-1:0];
        lo_nx_s  = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nx_s = mul_sum_s[WIDTH:1];
      lo_nx_s  = {mul_sum_s[0], lo_q[WIDTH-1:1]};
    end
  end

  // Next-state selection: load beats step, otherwise hold.
  always_comb begin
    acc_d = acc_q;
    lo_d  = lo_q;
    b_d   = b_q;
    div_d = div_q;
    if (load) begin
      acc_d = {WIDTH{1'b0}};
      lo_d  = a;
      b_d   = b;
      div_d = is_div;
    end else if (step) begin
      acc_d = acc_nx_s;
      lo_d  = lo_nx_s;
    end else begin
      acc_d = acc_q;
      lo_d  = lo_q;
    end
  end

  // Engine state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= {WIDTH{1'b0}};
      lo_q  <= {WIDTH{1'b0}};
      b_q   <= {WIDTH{1'b0}};
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
    end
  end

  assign prod_hi = acc_nx_s;
  assign prod_lo = lo_nx_s;
  assign rem     = acc_nx_s;
  assign quot    = lo_nx_s;

endmodule

// File: rtl/neander_seq_alu.sv
// neander_seq_alu: multi-cycle NEANDER ALU with start/busy/done handshake.
//   clk, reset (async, active-high)
//   start, op, a, b, carry_in  - request; operands sampled when accepted
//   busy                       - iterative op in progress
//   done                       - one-cycle pulse, outputs below are valid
//   result, result_hi          - AC / Y results
//   carry_out, zero, negative, overflow, div_by_zero - registered flags
// Macro NEANDER_SEQ_ALU_MULDIV_EN enables the MUL/DIV/MOD engine; without it
// those opcodes complete in one cycle with a zero result.
module neander_seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             div_by_zero
);
  import neander_alu_pkg::*;

`ifdef NEANDER_SEQ_ALU_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

  alu_state_e       state_q, state_d;
  alu_op_e          op_q, op_d, op_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
  logic             carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
  logic             ovf_q, ovf_d, dbz_q, dbz_d;

  logic             accept_s, is_iter_s, cin_s;
  logic [WIDTH:0]   sum_s, diff_s;
  logic [WIDTH-1:0] sc_res_s, sc_hi_s, fin_res_s, fin_hi_s;
  logic             sc_c_s, sc_v_s, sc_dbz_s, fin_c_s;
  logic [WIDTH-1:0] eng_hi_s, eng_lo_s, eng_quot_s, eng_rem_s;
  logic             ld_s, ld_c_s, ld_v_s, ld_dbz_s;
  logic [WIDTH-1:0] ld_res_s, ld_hi_s;

  assign op_s     = alu_op_e'(op);
  assign accept_s = start && (state_q != ST_RUN);
  // DIV/MOD by zero resolves in one cycle, so only nonzero divisors iterate.
  assign is_iter_s = MULDIV_EN && ((op_s == OP_MUL) ||
                     (((op_s == OP_DIV) || (op_s == OP_MOD)) && (b != {WIDTH{1'b0}})));

`ifdef NEANDER_SEQ_ALU_MULDIV_EN
  logic eng_load_s, eng_step_s;
  assign eng_load_s = accept_s && is_iter_s;
  assign eng_step_s = (state_q == ST_RUN);

  neander_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .load    (eng_load_s),
    .is_div  (op_s != OP_MUL),
    .a       (a),
    .b       (b),
    .step    (eng_step_s),
    .prod_hi (eng_hi_s),
    .prod_lo (eng_lo_s),
    .quot    (eng_quot_s),
    .rem     (eng_rem_s)
  );
`else
  assign eng_hi_s   = {WIDTH{1'b0}};
  assign eng_lo_s   = {WIDTH{1'b0}};
  assign eng_quot_s = {WIDTH{1'b0}};
  assign eng_rem_s  = {WIDTH{1'b0}};
`endif

  // Single-cycle datapath on the live inputs (used only at accept).
  always_comb begin
    cin_s    = ((op_s == OP_ADC) || (op_s == OP_SBC)) ? carry_in : 1'b0;
    sum_s    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_s};
    diff_s   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_s};
    sc_res_s = {WIDTH{1'b0}};
    sc_hi_s  = {WIDTH{1'b0}};
    sc_c_s   = 1'b0;
    sc_v_s   = 1'b0;
    sc_dbz_s = 1'b0;
    case (op_s)
      OP_ADD, OP_ADC: begin
        sc_res_s = sum_s[WIDTH-1:0];
        sc_c_s   = sum_s[WIDTH];
        sc_v_s   = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        sc_res_s = diff_s[WIDTH-1:0];
        sc_c_s   = diff_s[WIDTH];
        sc_v_s   = sub_ovf(a[WIDTH-1], b[WIDTH-1], diff_s[WIDTH-1]);
      end
      OP_AND: sc_res_s = a & b;
      OP_OR:  sc_res_s = a | b;
      OP_XOR: sc_res_s = a ^ b;
      OP_NOT: sc_res_s = ~a;
      OP_SHL: begin
        sc_res_s = {a[WIDTH-2:0], 1'b0};
        sc_c_s   = a[WIDTH-1];
      end
      OP_SHR: begin
        sc_res_s = {1'b0, a[WIDTH-1:1]};
        sc_c_s   = a[0];
      end
      OP_ASR: begin
        sc_res_s = {a[WIDTH-1], a[WIDTH-1:1]};
        sc_c_s   = a[0];
      end
      OP_NEG: begin
        sc_res_s = {WIDTH{1'b0}} - a;
        sc_c_s   = (a != {WIDTH{1'b0}});
        sc_v_s   = (a == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_DIV: begin
        if (MULDIV_EN && (b == {WIDTH{1'b0}})) begin
          sc_res_s = {WIDTH{1'b1}};
          sc_hi_s  = a;
          sc_c_s   = 1'b1;
          sc_dbz_s = 1'b1;
        end else begin
          sc_res_s = {WIDTH{1'b0}};
        end
      end
      OP_MOD: begin
        if (MULDIV_EN && (b == {WIDTH{1'b0}})) begin
          sc_res_s = a;
          sc_hi_s  = {WIDTH{1'b1}};
          sc_c_s   = 1'b1;
          sc_dbz_s = 1'b1;
        end else begin
          sc_res_s = {WIDTH{1'b0}};
        end
      end
      default: sc_res_s = {WIDTH{1'b0}};  // MUL when disabled, reserved
    endcase
  end

  // Final iterative result from the engine's last step.
  always_comb begin
    fin_res_s = {WIDTH{1'b0}};
    fin_hi_s  = {WIDTH{1'b0}};
    fin_c_s   = 1'b0;
    case (op_q)
      OP_MUL: begin
        fin_res_s = eng_lo_s;
        fin_hi_s  = eng_hi_s;
        fin_c_s   = (eng_hi_s != {WIDTH{1'b0}});
      end
      OP_DIV: begin
        fin_res_s = eng_quot_s;
        fin_hi_s  = eng_rem_s;
      end
      OP_MOD: begin
        fin_res_s = eng_rem_s;
        fin_hi_s  = eng_quot_s;
      end
      default: fin_res_s = {WIDTH{1'b0}};
    endcase
  end

  // FSM next state and output-register load control.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ld_s     = 1'b0;
    ld_res_s = sc_res_s;
    ld_hi_s  = sc_hi_s;
    ld_c_s   = sc_c_s;
    ld_v_s   = sc_v_s;
    ld_dbz_s = sc_dbz_s;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          op_d = op_s;
          if (is_iter_s) begin
            state_d = ST_RUN;
            cnt_d   = CNT_W'(WIDTH);
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            ld_s    = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_DONE;
          cnt_d    = {CNT_W{1'b0}};
          busy_d   = 1'b0;
          done_d   = 1'b1;
          ld_s     = 1'b1;
          ld_res_s = fin_res_s;
          ld_hi_s  = fin_hi_s;
          ld_c_s   = fin_c_s;
          ld_v_s   = 1'b0;
          ld_dbz_s = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    result_d = result_q;
    hi_d     = hi_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    if (ld_s) begin
      result_d = ld_res_s;
      hi_d     = ld_hi_s;
      carry_d  = ld_c_s;
      ovf_d    = ld_v_s;
      dbz_d    = ld_dbz_s;
      zero_d   = (ld_res_s == {WIDTH{1'b0}});
      neg_d    = ld_res_s[WIDTH-1];
    end else begin
      result_d = result_q;
    end
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign result_hi   = hi_q;
  assign carry_out   = carry_q;
  assign zero        = zero_q;
  assign negative    = neg_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_neander_seq_alu.sv
// Directed bench for neander_seq_alu: a WIDTH=8 and a WIDTH=16 instance.
// Expectations for MUL/DIV/MOD follow NEANDER_SEQ_ALU_MULDIV_EN.
module tb_neander_seq_alu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start8, cin8, busy8, done8, co8, z8, n8, v8, dbz8;
  logic [3:0] op8;
  logic [7:0] a8, b8, res8, hi8;

  logic        start16, cin16, busy16, done16, co16, z16, n16, v16, dbz16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, res16, hi16;

  neander_seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .carry_in(cin8), .busy(busy8), .done(done8), .result(res8),
    .result_hi(hi8), .carry_out(co8), .zero(z8), .negative(n8),
    .overflow(v8), .div_by_zero(dbz8)
  );

  neander_seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
    .carry_in(cin16), .busy(busy16), .done(done16), .result(res16),
    .result_hi(hi16), .carry_out(co16), .zero(z16), .negative(n16),
    .overflow(v16), .div_by_zero(dbz16)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic [7:0] hi;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
  } vec_t;

  // Present a request before a rising edge; scramble operands right after it.
  task automatic issue8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic c);
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y; cin8 = c;
    @(posedge clk);
    #1;
    start8 = 1'b0; op8 = 4'h3; a8 = 8'h5A; b8 = 8'hA5; cin8 = ~c;
  endtask

  task automatic issue16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    start16 = 1'b1; op16 = o; a16 = x; b16 = y; cin16 = 1'b0;
    @(posedge clk);
    #1;
    start16 = 1'b0; op16 = 4'h0; a16 = 16'hFFFF; b16 = 16'hFFFF;
  endtask

  // Count edges after accept until done is seen; optionally pulse start8
  // (an ADD request) while the run is in progress. Bounded at 40 edges.
  task automatic wait_done(input bit wide, input int inject_at,
                           output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!(wide ? done16 : done8) && lat < 40) begin
      if (wide ? busy16 : busy8) busy_n++;
      @(negedge clk);
      if (lat == inject_at) begin
        start8 = 1'b1; op8 = 4'h0; a8 = 8'h01; b8 = 8'h01;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start8 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if ({busy8, done8, res8, hi8, co8, z8, n8, v8, dbz8} !== 23'd0) begin
      n_errors++;
      $display("FAIL reset8: got %h want 0", {busy8, done8, res8, hi8, co8, z8, n8, v8, dbz8});
    end
    n_checks++;
    if ({busy16, done16, res16, hi16, co16, z16, n16, v16, dbz16} !== 39'd0) begin
      n_errors++;
      $display("FAIL reset16: got %h want 0",
               {busy16, done16, res16, hi16, co16, z16, n16, v16, dbz16});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_cycle;
    vec_t vt[14];
    logic [20:0] exp_v;
    vt[0]  = {4'h0, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}; // ADD
    vt[1]  = {4'h1, 8'h50, 8'hB0, 1'b0, 8'hA0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1}; // SUB
    vt[2]  = {4'hC, 8'h7F, 8'h00, 1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1}; // ADC
    vt[3]  = {4'hD, 8'h10, 8'h01, 1'b1, 8'h0E, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}; // SBC
    vt[4]  = {4'h2, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}; // AND
    vt[5]  = {4'h3, 8'hF0, 8'h0F, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}; // OR
    vt[6]  = {4'h4, 8'hAA, 8'hFF, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}; // XOR
    vt[7]  = {4'h5, 8'h0F, 8'h00, 1'b0, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}; // NOT
    vt[8]  = {4'h6, 8'h81, 8'h00, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}; // SHL
    vt[9]  = {4'h7, 8'h81, 8'h00, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}; // SHR
    vt[10] = {4'hE, 8'h81, 8'h00, 1'b0, 8'hC0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}; // ASR
    vt[11] = {4'h8, 8'h80, 8'h00, 1'b0, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1}; // NEG min
    vt[12] = {4'h8, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}; // NEG 0
    vt[13] = {4'hF, 8'h12, 8'h34, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}; // reserved
    for (int i = 0; i < 14; i++) begin
      issue8(vt[i].op, vt[i].a, vt[i].b, vt[i].cin);
      n_checks++;
      if ({busy8, done8} !== 2'b01) begin
        n_errors++;
        $display("FAIL single_hs[%0d] op %h: busy/done %b want 01", i, vt[i].op, {busy8, done8});
      end
      exp_v = {vt[i].res, vt[i].hi, vt[i].c, vt[i].z, vt[i].n, vt[i].v, 1'b0};
      n_checks++;
      if ({res8, hi8, co8, z8, n8, v8, dbz8} !== exp_v) begin
        n_errors++;
        $display("FAIL single_out[%0d] op %h: got %h want %h", i, vt[i].op,
                 {res8, hi8, co8, z8, n8, v8, dbz8}, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back;
    issue8(4'h0, 8'h02, 8'h03, 1'b0);
    n_checks++;
    if ({done8, res8} !== {1'b1, 8'h05}) begin
      n_errors++;
      $display("FAIL b2b_first: got %h want 105", {done8, res8});
    end
    // New request in the DONE cycle must be accepted immediately.
    issue8(4'h1, 8'h09, 8'h03, 1'b0);
    n_checks++;
    if ({done8, res8} !== {1'b1, 8'h06}) begin
      n_errors++;
      $display("FAIL b2b_second: got %h want 106", {done8, res8});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({done8, res8} !== {1'b0, 8'h06}) begin
      n_errors++;
      $display("FAIL done_pulse_hold: got %h want 006", {done8, res8});
    end
  endtask

  task automatic test_muldiv;
    int lat, bn;
    logic [20:0] exp_v;
`ifdef NEANDER_SEQ_ALU_MULDIV_EN
    // MUL FF*FF with an ignored start pulse mid-run.
    issue8(4'h9, 8'hFF, 8'hFF, 1'b0);
    wait_done(1'b0, 3, lat, bn);
    n_checks++;
    if (lat !== 8 || bn !== 8) begin
      n_errors++;
      $display("FAIL mul_timing: latency %0d busy %0d want 8 8", lat, bn);
    end
    n_checks++;
    if ({busy8, res8, hi8, co8, z8, n8, v8, dbz8} !== {1'b0, 8'h01, 8'hFE, 5'b10000}) begin
      n_errors++;
      $display("FAIL mul_out: got %h", {busy8, res8, hi8, co8, z8, n8, v8, dbz8});
    end
    issue8(4'hA, 8'd200, 8'd7, 1'b0);
    wait_done(1'b0, -1, lat, bn);
    n_checks++;
    if (lat !== 8 || {res8, hi8, co8, z8, n8, v8, dbz8} !== {8'h1C, 8'h04, 5'b00000}) begin
      n_errors++;
      $display("FAIL div_out: lat %0d got %h want 8 1c0400", lat, {res8, hi8, co8, z8, n8, v8, dbz8});
    end
    issue8(4'hB, 8'd200, 8'd7, 1'b0);
    wait_done(1'b0, -1, lat, bn);
    n_checks++;
    if (lat !== 8 || {res8, hi8, co8, z8, n8, v8, dbz8} !== {8'h04, 8'h1C, 5'b00000}) begin
      n_errors++;
      $display("FAIL mod_out: lat %0d got %h", lat, {res8, hi8, co8, z8, n8, v8, dbz8});
    end
    issue8(4'hA, 8'hC8, 8'h00, 1'b0);
    exp_v = {8'hFF, 8'hC8, 5'b10101};
    n_checks++;
    if ({busy8, done8} !== 2'b01 || {res8, hi8, co8, z8, n8, v8, dbz8} !== exp_v) begin
      n_errors++;
      $display("FAIL div0: got %b %h want 01 %h", {busy8, done8}, {res8, hi8, co8, z8, n8, v8, dbz8}, exp_v);
    end
    issue8(4'hB, 8'hC8, 8'h00, 1'b0);
    exp_v = {8'hC8, 8'hFF, 5'b10101};
    n_checks++;
    if ({busy8, done8} !== 2'b01 || {res8, hi8, co8, z8, n8, v8, dbz8} !== exp_v) begin
      n_errors++;
      $display("FAIL mod0: got %b %h want 01 %h", {busy8, done8}, {res8, hi8, co8, z8, n8, v8, dbz8}, exp_v);
    end
    issue16(4'h9, 16'h1234, 16'h0100);
    wait_done(1'b1, -1, lat, bn);
    n_checks++;
    if (lat !== 16 || bn !== 16 || {res16, hi16, co16, z16} !== {16'h3400, 16'h0012, 2'b10}) begin
      n_errors++;
      $display("FAIL mul16: lat %0d busy %0d got %h", lat, bn, {res16, hi16, co16, z16});
    end
`else
    issue8(4'h9, 8'hFF, 8'hFF, 1'b0);
    wait_done(1'b0, -1, lat, bn);
    n_checks++;
    if (lat !== 0 || bn !== 0 || {res8, hi8, co8, z8, n8, v8, dbz8} !== {16'h0000, 5'b01000}) begin
      n_errors++;
      $display("FAIL mul_off: lat %0d busy %0d got %h", lat, bn, {res8, hi8, co8, z8, n8, v8, dbz8});
    end
    issue8(4'hA, 8'hC8, 8'h00, 1'b0);
    n_checks++;
    if ({busy8, done8, res8, hi8, co8, z8, n8, v8, dbz8} !== {2'b01, 16'h0000, 5'b01000}) begin
      n_errors++;
      $display("FAIL div0_off: got %h", {busy8, done8, res8, hi8, co8, z8, n8, v8, dbz8});
    end
    issue16(4'h9, 16'h1234, 16'h0100);
    n_checks++;
    if ({busy16, done16, res16, hi16, z16} !== {2'b01, 32'h0, 1'b1}) begin
      n_errors++;
      $display("FAIL mul16_off: got %h", {busy16, done16, res16, hi16, z16});
    end
`endif
  endtask

  task automatic test_reset_mid_run;
    bit seen_done;
    issue8(4'h9, 8'hFF, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy8, done8, res8, hi8, co8, z8, n8, v8, dbz8} !== 23'd0) begin
      n_errors++;
      $display("FAIL reset_mid: got %h want 0", {busy8, done8, res8, hi8, co8, z8, n8, v8, dbz8});
    end
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done8 || busy8) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_no_done: activity %b want 0", seen_done);
    end
    issue8(4'h0, 8'h02, 8'h03, 1'b0);
    n_checks++;
    if ({done8, res8, co8, z8} !== {1'b1, 8'h05, 2'b00}) begin
      n_errors++;
      $display("FAIL add_after_reset: got %h want 1050", {done8, res8, co8, z8});
    end
  endtask

  initial begin
    start8 = 1'b0; op8 = 4'h0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start16 = 1'b0; op16 = 4'h0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
    test_reset();
    test_single_cycle();
    test_back_to_back();
    test_muldiv();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
